// File: rtl/issue_unit_pkg.sv
// Shared types and constants for the issue stage.
// Register-file geometry, exec-unit indices and the held-instruction bundle.
package issue_unit_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int NUM_GPR    = 32;
  localparam int EXEC_SEL_W = 3;

  typedef logic [GPR_ADDR_W-1:0] gpr_t;

  typedef enum logic [EXEC_SEL_W-1:0] {
    EU_ALU    = 3'd0,
    EU_BRANCH = 3'd1,
    EU_LSU    = 3'd2,
    EU_MUL    = 3'd3,
    EU_CSR    = 3'd4
  } exec_unit_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic [EXEC_SEL_W-1:0] sel;
    gpr_t                  a;
    gpr_t                  b;
    gpr_t                  rd;
    logic                  uses_a;
    logic                  uses_b;
    logic                  writes_rd;
  } issue_instr_t;

  // x0 is hardwired, so it never maps to a pending bit.
  function automatic logic [NUM_GPR-1:0] gpr_onehot(
    input gpr_t r,
    input logic en
  );
    gpr_onehot = '0;
    if (en && (r != '0))
      gpr_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Decode, dispatch, writeback and debug signals of the issue stage.
// slave is the issue unit's view; master is the surrounding pipeline's.
interface issue_unit_if
  import issue_unit_pkg::*;
#(
  parameter int NUM_UNITS   = 5,
  parameter int STALL_CNT_W = 16
);

  logic                   dec_valid_in;
  logic                   dec_ready_out;
  logic [EXEC_SEL_W-1:0]  dec_exec_unit_sel_in;
  gpr_t                   dec_gpr_src_a_in;
  gpr_t                   dec_gpr_src_b_in;
  gpr_t                   dec_gpr_des_in;
  logic                   dec_uses_a_in;
  logic                   dec_uses_b_in;
  logic                   dec_writes_rd_in;

  logic [NUM_UNITS-1:0]   exec_ready_in;
  logic                   issue_valid_out;
  logic [EXEC_SEL_W-1:0]  issue_exec_unit_sel_out;
  gpr_t                   issue_gpr_a_out;
  gpr_t                   issue_gpr_b_out;
  gpr_t                   issue_gpr_rd_out;

  logic                   wb_valid_in;
  gpr_t                   wb_rd_in;
  logic                   issue_flush_in;

  logic                   illegal_sel_out;
  logic [STALL_CNT_W-1:0] stall_count_out;
  logic [NUM_GPR-1:0]     scoreboard_out;

  modport slave (
    input  dec_valid_in,
    output dec_ready_out,
    input  dec_exec_unit_sel_in,
    input  dec_gpr_src_a_in,
    input  dec_gpr_src_b_in,
    input  dec_gpr_des_in,
    input  dec_uses_a_in,
    input  dec_uses_b_in,
    input  dec_writes_rd_in,
    input  exec_ready_in,
    output issue_valid_out,
    output issue_exec_unit_sel_out,
    output issue_gpr_a_out,
    output issue_gpr_b_out,
    output issue_gpr_rd_out,
    input  wb_valid_in,
    input  wb_rd_in,
    input  issue_flush_in,
    output illegal_sel_out,
    output stall_count_out,
    output scoreboard_out
  );

  modport master (
    output dec_valid_in,
    input  dec_ready_out,
    output dec_exec_unit_sel_in,
    output dec_gpr_src_a_in,
    output dec_gpr_src_b_in,
    output dec_gpr_des_in,
    output dec_uses_a_in,
    output dec_uses_b_in,
    output dec_writes_rd_in,
    output exec_ready_in,
    input  issue_valid_out,
    input  issue_exec_unit_sel_out,
    input  issue_gpr_a_out,
    input  issue_gpr_b_out,
    input  issue_gpr_rd_out,
    output wb_valid_in,
    output wb_rd_in,
    output issue_flush_in,
    input  illegal_sel_out,
    input  stall_count_out,
    input  scoreboard_out
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Pending-destination scoreboard with a three-port hazard lookup.
// Writeback clears are bypassed into the lookup in the same cycle.
module issue_scoreboard
  import issue_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_set_en,
  input  gpr_t               i_set_rd,
  input  logic               i_clr_en,
  input  gpr_t               i_clr_rd,
  input  gpr_t               i_src_a,
  input  gpr_t               i_src_b,
  input  gpr_t               i_rd,
  input  logic               i_uses_a,
  input  logic               i_uses_b,
  input  logic               i_writes_rd,
  output logic               o_hazard,
  output logic [NUM_GPR-1:0] o_sb
);

  logic [NUM_GPR-1:0] r_sb;
  logic [NUM_GPR-1:0] w_set;
  logic [NUM_GPR-1:0] w_clr;
  logic [NUM_GPR-1:0] w_eff;

  assign w_set = gpr_onehot(i_set_rd, i_set_en);
  assign w_clr = gpr_onehot(i_clr_rd, i_clr_en);
  assign w_eff = r_sb & ~w_clr;

  // rd term is the WAW check; bit 0 is never set.
  assign o_hazard = (i_uses_a    & w_eff[i_src_a])
                  | (i_uses_b    & w_eff[i_src_b])
                  | (i_writes_rd & w_eff[i_rd]);

  assign o_sb = r_sb;

  // Set is ORed after the clear so a colliding dispatch wins.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_sb <= '0;
    else
      r_sb <= w_eff | w_set;
  end

endmodule

// File: rtl/issue_unit.sv
// Single-entry issue stage: holds one decoded op until its
// hazards clear and its execution unit is ready, then dispatches.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int NUM_UNITS   = 5,
  parameter int STALL_CNT_W = 16
) (
  input logic          issue_clock_in,
  input logic          issue_reset_in,
  issue_unit_if.slave  io
);

  issue_state_e           r_state;
  issue_instr_t           r_ins;
  logic [STALL_CNT_W-1:0] r_stall;

  issue_instr_t w_dec_ins;
  logic         w_hold;
  logic         w_legal;
  logic         w_unit_rdy;
  logic         w_hazard;
  logic         w_issue;
  logic         w_fire;
  logic         w_drop;
  logic         w_ready;
  logic         w_accept;
  logic         w_stall;
  logic         w_flush;

  assign w_flush = io.issue_flush_in;

  always_comb begin
    w_dec_ins           = '0;
    w_dec_ins.sel       = io.dec_exec_unit_sel_in;
    w_dec_ins.a         = io.dec_gpr_src_a_in;
    w_dec_ins.b         = io.dec_gpr_src_b_in;
    w_dec_ins.rd        = io.dec_gpr_des_in;
    w_dec_ins.uses_a    = io.dec_uses_a_in;
    w_dec_ins.uses_b    = io.dec_uses_b_in;
    w_dec_ins.writes_rd = io.dec_writes_rd_in;
  end

  assign w_hold  = (r_state == ST_HOLD);
  assign w_legal = 32'(r_ins.sel) < NUM_UNITS;

  // Out-of-range selects never match, so no illegal index is formed.
  always_comb begin
    w_unit_rdy = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (32'(r_ins.sel) == u)
        w_unit_rdy = io.exec_ready_in[u];
    end
  end

  issue_scoreboard u_sb (
    .i_clk       (issue_clock_in),
    .i_rst       (issue_reset_in),
    .i_set_en    (w_fire & r_ins.writes_rd),
    .i_set_rd    (r_ins.rd),
    .i_clr_en    (io.wb_valid_in),
    .i_clr_rd    (io.wb_rd_in),
    .i_src_a     (r_ins.a),
    .i_src_b     (r_ins.b),
    .i_rd        (r_ins.rd),
    .i_uses_a    (r_ins.uses_a),
    .i_uses_b    (r_ins.uses_b),
    .i_writes_rd (r_ins.writes_rd),
    .o_hazard    (w_hazard),
    .o_sb        (io.scoreboard_out)
  );

  assign w_issue  = w_hold & ~w_hazard & w_legal & ~w_flush;
  assign w_fire   = w_issue & w_unit_rdy;
  assign w_drop   = w_hold & ~w_legal & ~w_flush;
  assign w_ready  = ~w_flush & (~w_hold | w_fire | w_drop);
  assign w_accept = io.dec_valid_in & w_ready;
  assign w_stall  = w_hold & ~w_fire & ~w_drop & ~w_flush;

  always_ff @(posedge issue_clock_in) begin
    if (issue_reset_in) begin
      r_state <= ST_EMPTY;
      r_ins   <= '0;
      r_stall <= '0;
    end else begin
      if (w_accept) begin
        r_state <= ST_HOLD;
        r_ins   <= w_dec_ins;
      end else if (w_fire | w_drop | w_flush) begin
        r_state <= ST_EMPTY;
      end
      if (w_stall && !(&r_stall))
        r_stall <= r_stall + 1'b1;
    end
  end

  assign io.dec_ready_out           = w_ready;
  assign io.issue_valid_out         = w_issue;
  assign io.issue_exec_unit_sel_out = r_ins.sel;
  assign io.issue_gpr_a_out         = r_ins.a;
  assign io.issue_gpr_b_out         = r_ins.b;
  assign io.issue_gpr_rd_out        = r_ins.rd;
  assign io.illegal_sel_out         = w_drop;
  assign io.stall_count_out         = r_stall;

endmodule

// File: tb/tb_issue_unit.sv
// Directed scenarios plus a randomized run against a
// behavioural model of the issue stage.
module tb_issue_unit;
  import issue_unit_pkg::*;

  localparam int NU = 5;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  issue_unit_if #(.NUM_UNITS(NU), .STALL_CNT_W(SW)) bus ();

  issue_unit #(.NUM_UNITS(NU), .STALL_CNT_W(SW)) dut (
    .issue_clock_in (clk),
    .issue_reset_in (rst),
    .io             (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_op(input logic v, input logic [2:0] sel,
                        input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] rd, input logic ua,
                        input logic ub, input logic wr);
    bus.dec_valid_in         = v;
    bus.dec_exec_unit_sel_in = sel;
    bus.dec_gpr_src_a_in     = a;
    bus.dec_gpr_src_b_in     = b;
    bus.dec_gpr_des_in       = rd;
    bus.dec_uses_a_in        = ua;
    bus.dec_uses_b_in        = ub;
    bus.dec_writes_rd_in     = wr;
  endtask

  task automatic do_reset();
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    bus.exec_ready_in  = '1;
    bus.wb_valid_in    = 1'b0;
    bus.wb_rd_in       = '0;
    bus.issue_flush_in = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", bus.issue_valid_out); end
    n_checks++; if (bus.dec_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", bus.dec_ready_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h0) begin n_fail++; $display("FAIL rst_sb got=%h exp=0", bus.scoreboard_out); end
    n_checks++; if (bus.stall_count_out !== 16'h0) begin n_fail++; $display("FAIL rst_stall got=%0d exp=0", bus.stall_count_out); end
    n_checks++; if (bus.illegal_sel_out !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got=%b exp=0", bus.illegal_sel_out); end
    n_checks++; if ({bus.issue_exec_unit_sel_out, bus.issue_gpr_a_out, bus.issue_gpr_b_out, bus.issue_gpr_rd_out} !== 18'h0) begin n_fail++; $display("FAIL rst_fields got=%h exp=0", {bus.issue_exec_unit_sel_out, bus.issue_gpr_a_out, bus.issue_gpr_b_out, bus.issue_gpr_rd_out}); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_op(1, EU_ALU, 0, 0, 1, 0, 0, 1);
    settle();
    n_checks++; if (bus.dec_ready_out !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy0 got=%b exp=1", bus.dec_ready_out); end
    tick();
    set_op(1, EU_ALU, 0, 0, 2, 0, 0, 1);
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_v1 got=%b exp=1", bus.issue_valid_out); end
    n_checks++; if (bus.issue_gpr_rd_out !== 5'd1) begin n_fail++; $display("FAIL b2b_rd1 got=%0d exp=1", bus.issue_gpr_rd_out); end
    n_checks++; if (bus.dec_ready_out !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy1 got=%b exp=1", bus.dec_ready_out); end
    tick();
    bus.dec_valid_in = 1'b0;
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_v2 got=%b exp=1", bus.issue_valid_out); end
    n_checks++; if (bus.issue_gpr_rd_out !== 5'd2) begin n_fail++; $display("FAIL b2b_rd2 got=%0d exp=2", bus.issue_gpr_rd_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h2) begin n_fail++; $display("FAIL b2b_sb2 got=%h exp=2", bus.scoreboard_out); end
    tick();
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_v3 got=%b exp=0", bus.issue_valid_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h6) begin n_fail++; $display("FAIL b2b_sb got=%h exp=6", bus.scoreboard_out); end
    tick();
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_op(1, EU_ALU, 0, 0, 5, 0, 0, 1);
    settle(); tick();
    set_op(1, EU_ALU, 5, 0, 6, 1, 0, 1);
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b1) begin n_fail++; $display("FAIL raw_first got=%b exp=1", bus.issue_valid_out); end
    tick();
    bus.dec_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL raw_hold%0d got=%b exp=0", i, bus.issue_valid_out); end
      tick();
    end
    bus.wb_valid_in = 1'b1;
    bus.wb_rd_in    = 5'd5;
    settle();
    n_checks++; if (bus.stall_count_out !== 16'd3) begin n_fail++; $display("FAIL raw_stall got=%0d exp=3", bus.stall_count_out); end
    n_checks++; if (bus.issue_valid_out !== 1'b1) begin n_fail++; $display("FAIL raw_bypass got=%b exp=1", bus.issue_valid_out); end
    n_checks++; if (bus.issue_gpr_a_out !== 5'd5) begin n_fail++; $display("FAIL raw_a got=%0d exp=5", bus.issue_gpr_a_out); end
    tick();
    bus.wb_valid_in = 1'b0;
    settle();
    n_checks++; if (bus.scoreboard_out !== 32'h40) begin n_fail++; $display("FAIL raw_sb got=%h exp=40", bus.scoreboard_out); end
    n_checks++; if (bus.stall_count_out !== 16'd3) begin n_fail++; $display("FAIL raw_stall_end got=%0d exp=3", bus.stall_count_out); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.exec_ready_in = 5'b11011;
    set_op(1, EU_LSU, 1, 2, 8, 1, 1, 1);
    settle(); tick();
    set_op(1, EU_ALU, 0, 0, 9, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++; if (bus.issue_valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d got=%b exp=1", i, bus.issue_valid_out); end
      n_checks++; if ({bus.issue_exec_unit_sel_out, bus.issue_gpr_a_out, bus.issue_gpr_b_out, bus.issue_gpr_rd_out} !== {3'd2, 5'd1, 5'd2, 5'd8}) begin n_fail++; $display("FAIL bp_fields%0d got=%h", i, {bus.issue_exec_unit_sel_out, bus.issue_gpr_a_out, bus.issue_gpr_b_out, bus.issue_gpr_rd_out}); end
      n_checks++; if (bus.dec_ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_rdy%0d got=%b exp=0", i, bus.dec_ready_out); end
      tick();
    end
    bus.exec_ready_in = '1;
    settle();
    n_checks++; if (bus.dec_ready_out !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b exp=1", bus.dec_ready_out); end
    tick();
    bus.dec_valid_in = 1'b0;
    settle();
    n_checks++; if (bus.issue_gpr_rd_out !== 5'd9) begin n_fail++; $display("FAIL bp_next got=%0d exp=9", bus.issue_gpr_rd_out); end
    n_checks++; if (bus.stall_count_out !== 16'd4) begin n_fail++; $display("FAIL bp_stall got=%0d exp=4", bus.stall_count_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h100) begin n_fail++; $display("FAIL bp_sb got=%h exp=100", bus.scoreboard_out); end
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    set_op(1, EU_ALU, 0, 0, 7, 0, 0, 1);
    settle(); tick();
    settle(); tick();
    bus.dec_valid_in = 1'b0;
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL col_waw got=%b exp=0", bus.issue_valid_out); end
    tick();
    bus.wb_valid_in = 1'b1;
    bus.wb_rd_in    = 5'd7;
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b1) begin n_fail++; $display("FAIL col_fire got=%b exp=1", bus.issue_valid_out); end
    tick();
    bus.wb_valid_in = 1'b0;
    settle();
    n_checks++; if (bus.scoreboard_out !== 32'h80) begin n_fail++; $display("FAIL col_sb got=%h exp=80", bus.scoreboard_out); end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    set_op(1, EU_ALU, 0, 0, 3, 0, 0, 1);
    settle(); tick();
    set_op(1, 3'd6, 0, 0, 9, 0, 0, 1);
    settle(); tick();
    bus.dec_valid_in = 1'b0;
    settle();
    n_checks++; if (bus.illegal_sel_out !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got=%b exp=1", bus.illegal_sel_out); end
    n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL ill_valid got=%b exp=0", bus.issue_valid_out); end
    n_checks++; if (bus.dec_ready_out !== 1'b1) begin n_fail++; $display("FAIL ill_rdy got=%b exp=1", bus.dec_ready_out); end
    tick();
    settle();
    n_checks++; if (bus.illegal_sel_out !== 1'b0) begin n_fail++; $display("FAIL ill_once got=%b exp=0", bus.illegal_sel_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h8) begin n_fail++; $display("FAIL ill_sb got=%h exp=8", bus.scoreboard_out); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_op(1, EU_ALU, 0, 0, 4, 0, 0, 1);
    settle(); tick();
    set_op(1, EU_MUL, 0, 0, 10, 0, 0, 1);
    bus.exec_ready_in = 5'b10111;
    settle(); tick();
    set_op(1, EU_ALU, 0, 0, 11, 0, 0, 1);
    bus.issue_flush_in = 1'b1;
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%b exp=0", bus.issue_valid_out); end
    n_checks++; if (bus.dec_ready_out !== 1'b0) begin n_fail++; $display("FAIL fl_rdy got=%b exp=0", bus.dec_ready_out); end
    tick();
    bus.issue_flush_in = 1'b0;
    bus.dec_valid_in   = 1'b0;
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL fl_empty got=%b exp=0", bus.issue_valid_out); end
    n_checks++; if (bus.dec_ready_out !== 1'b1) begin n_fail++; $display("FAIL fl_rdy2 got=%b exp=1", bus.dec_ready_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h10) begin n_fail++; $display("FAIL fl_sb got=%h exp=10", bus.scoreboard_out); end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    set_op(1, EU_ALU, 0, 0, 0, 1, 1, 1);
    settle(); tick();
    bus.dec_valid_in = 1'b0;
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b1) begin n_fail++; $display("FAIL x0_valid got=%b exp=1", bus.issue_valid_out); end
    tick();
    bus.wb_valid_in = 1'b1;
    bus.wb_rd_in    = 5'd0;
    settle();
    n_checks++; if (bus.scoreboard_out !== 32'h0) begin n_fail++; $display("FAIL x0_sb got=%h exp=0", bus.scoreboard_out); end
    tick();
    bus.wb_valid_in = 1'b0;
  endtask

  task automatic test_reset_hold();
    do_reset();
    set_op(1, EU_ALU, 0, 0, 13, 0, 0, 1);
    settle(); tick();
    set_op(1, EU_LSU, 0, 0, 12, 0, 0, 1);
    settle(); tick();
    bus.dec_valid_in  = 1'b0;
    bus.exec_ready_in = '0;
    tick(); tick();
    settle();
    n_checks++; if (bus.stall_count_out !== 16'd2) begin n_fail++; $display("FAIL rh_stall got=%0d exp=2", bus.stall_count_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h2000) begin n_fail++; $display("FAIL rh_sb got=%h exp=2000", bus.scoreboard_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    n_checks++; if (bus.issue_valid_out !== 1'b0) begin n_fail++; $display("FAIL rh_valid got=%b exp=0", bus.issue_valid_out); end
    n_checks++; if (bus.scoreboard_out !== 32'h0) begin n_fail++; $display("FAIL rh_sb0 got=%h exp=0", bus.scoreboard_out); end
    n_checks++; if (bus.stall_count_out !== 16'd0) begin n_fail++; $display("FAIL rh_stall0 got=%0d exp=0", bus.stall_count_out); end
    n_checks++; if (bus.issue_gpr_rd_out !== 5'd0) begin n_fail++; $display("FAIL rh_rd got=%0d exp=0", bus.issue_gpr_rd_out); end
    n_checks++; if (bus.dec_ready_out !== 1'b1) begin n_fail++; $display("FAIL rh_rdy got=%b exp=1", bus.dec_ready_out); end
    tick();
  endtask

  task automatic test_random();
    bit [31:0]  pend;
    bit         mv;
    logic [2:0] ms;
    logic [4:0] ma, mb, mrd;
    bit         mua, mub, mwr;
    int         mstall;
    bit         blocked, legal, e_valid, e_fire, e_drop, e_ready;
    logic [4:0] wrd;
    bit         wv, fl;
    do_reset();
    pend = 0; mv = 0; mstall = 0;
    ms = 0; ma = 0; mb = 0; mrd = 0; mua = 0; mub = 0; mwr = 0;
    for (int c = 0; c < 3000; c++) begin
      set_op(($urandom % 10) < 6,
             (($urandom % 8) < 6) ? 3'($urandom % 5) : 3'(5 + $urandom % 3),
             5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
             1'($urandom), 1'($urandom), 1'($urandom));
      bus.exec_ready_in  = 5'($urandom);
      wv = ($urandom % 10) < 3;
      wrd = 5'($urandom % 8);
      fl = ($urandom % 20) == 0;
      bus.wb_valid_in    = wv;
      bus.wb_rd_in       = wrd;
      bus.issue_flush_in = fl;
      settle();
      blocked = 0;
      if (mua && ma != 0 && pend[ma] && !(wv && wrd == ma)) blocked = 1;
      if (mub && mb != 0 && pend[mb] && !(wv && wrd == mb)) blocked = 1;
      if (mwr && mrd != 0 && pend[mrd] && !(wv && wrd == mrd)) blocked = 1;
      legal   = int'(ms) < NU;
      e_valid = mv && !blocked && legal && !fl;
      e_fire  = e_valid && bus.exec_ready_in[ms];
      e_drop  = mv && !legal && !fl;
      e_ready = !fl && (!mv || e_fire || e_drop);
      n_checks++; if (bus.issue_valid_out !== e_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.issue_valid_out, e_valid); end
      n_checks++; if (bus.dec_ready_out !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.dec_ready_out, e_ready); end
      n_checks++; if (bus.illegal_sel_out !== e_drop) begin n_fail++; $display("FAIL rnd_illegal c=%0d got=%b exp=%b", c, bus.illegal_sel_out, e_drop); end
      n_checks++; if (bus.scoreboard_out !== pend) begin n_fail++; $display("FAIL rnd_sb c=%0d got=%h exp=%h", c, bus.scoreboard_out, pend); end
      n_checks++; if (int'(bus.stall_count_out) !== mstall) begin n_fail++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, bus.stall_count_out, mstall); end
      if (mv) begin
        n_checks++; if ({bus.issue_exec_unit_sel_out, bus.issue_gpr_a_out, bus.issue_gpr_b_out, bus.issue_gpr_rd_out} !== {ms, ma, mb, mrd}) begin n_fail++; $display("FAIL rnd_fields c=%0d got=%h exp=%h", c, {bus.issue_exec_unit_sel_out, bus.issue_gpr_a_out, bus.issue_gpr_b_out, bus.issue_gpr_rd_out}, {ms, ma, mb, mrd}); end
      end
      if (wv) pend[wrd] = 1'b0;
      if (e_fire && mwr && mrd != 0) pend[mrd] = 1'b1;
      if (mv && !e_fire && !e_drop && !fl && mstall < 65535) mstall++;
      if (bus.dec_valid_in && e_ready) begin
        mv = 1;
        ms = bus.dec_exec_unit_sel_in;
        ma = bus.dec_gpr_src_a_in;
        mb = bus.dec_gpr_src_b_in;
        mrd = bus.dec_gpr_des_in;
        mua = bus.dec_uses_a_in;
        mub = bus.dec_uses_b_in;
        mwr = bus.dec_writes_rd_in;
      end else if (e_fire || e_drop || fl) begin
        mv = 0;
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_raw_stall();
    test_backpressure();
    test_collision();
    test_illegal();
    test_flush();
    test_x0();
    test_reset_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
